// File: rtl/decimator.sv
// Switchable decimating FIR: averages each frame of D=2 or D=4 consumed
// samples, then outputs avg + the previous two frame averages (mod 2^W).
module decimator #(
  parameter int W = 8
) (
  input  logic         Clock,
  input  logic         reset,
  input  logic [W-1:0] in,
  input  logic         in_valid,
  input  logic         switch,
  output logic [W-1:0] out,
  output logic         out_valid
);

  typedef enum logic [1:0] {S0, S1, S2, S3} state_t;
  typedef enum logic {D2, D4} mode_t;

  state_t       r_state;
  mode_t        r_mode;
  logic [W+1:0] r_acc;
  logic [W-1:0] r_a1;
  logic [W-1:0] r_a2;
  logic [W-1:0] r_out;
  logic         r_out_valid;

  logic [W+1:0] w_sum;
  logic [W-1:0] w_avg;
  logic         w_last;
  state_t       w_next_state;

  // Running frame sum including the sample presented this cycle.
  assign w_sum = r_acc + {2'b00, in};

  // Last sample of the frame: S1 in D=2 mode, S3 in D=4 mode.
  assign w_last = ((r_state == S1) && (r_mode == D2)) || (r_state == S3);

  // Frame average by truncating shift; a bit-slice keeps only the low W bits.
  always_comb begin
    w_avg = w_sum[W:1];
    if (r_mode == D4) w_avg = w_sum[W+1:2];
  end

  // Frame index sequencing; the mode used here was latched at S0.
  always_comb begin
    w_next_state = S0;
    case (r_state)
      S0: w_next_state = S1;
      S1: w_next_state = (r_mode == D2) ? S0 : S2;
      S2: w_next_state = S3;
      S3: w_next_state = S0;
      default: w_next_state = S0;
    endcase
  end

  // Frame FSM, accumulator, tap history and registered outputs.
  always_ff @(posedge Clock) begin
    if (reset) begin
      r_state     <= S0;
      r_mode      <= D2;
      r_acc       <= '0;
      r_a1        <= '0;
      r_a2        <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (in_valid) begin
        r_state <= w_next_state;
        if (r_state == S0) r_mode <= switch ? D4 : D2;
        if (w_last) begin
          r_acc       <= '0;
          r_out       <= w_avg + r_a1 + r_a2;
          r_a2        <= r_a1;
          r_a1        <= w_avg;
          r_out_valid <= 1'b1;
        end else begin
          r_acc <= w_sum;
        end
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_decimator.sv
// Bench for decimator: directed scenarios plus randomized traffic, all
// checked every cycle against a frame-level reference model.
module tb_decimator;

  logic       clk;
  logic       t_reset;
  logic [7:0] t_in;
  logic       t_in_valid;
  logic       t_switch;
  logic [7:0] t_out;
  logic       t_out_valid;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_q[$];
  int m_d   = 2;
  int m_a1  = 0;
  int m_a2  = 0;
  int m_out = 0;
  int m_vld = 0;

  decimator #(.W(8)) dut (
    .Clock    (clk),
    .reset    (t_reset),
    .in       (t_in),
    .in_valid (t_in_valid),
    .switch   (t_switch),
    .out      (t_out),
    .out_valid(t_out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, compare both outputs.
  task automatic drive(input logic rst, input logic v, input logic s, input int d);
    int sum;
    int avg;
    t_reset = rst; t_in_valid = v; t_switch = s; t_in = d[7:0];
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_d = 2; m_a1 = 0; m_a2 = 0; m_out = 0; m_vld = 0;
    end else begin
      m_vld = 0;
      if (v) begin
        if (m_q.size() == 0) m_d = s ? 4 : 2;
        m_q.push_back(d & 255);
        if (m_q.size() == m_d) begin
          sum = 0;
          foreach (m_q[i]) sum += m_q[i];
          avg   = (sum / m_d) % 256;
          m_out = (avg + m_a1 + m_a2) % 256;
          m_a2  = m_a1;
          m_a1  = avg;
          m_vld = 1;
          m_q.delete();
        end
      end
    end
    #1;
    check("out", int'(t_out), m_out);
    check("out_valid", int'(t_out_valid), m_vld);
  endtask

  initial begin
    int vals24[6];
    int outs24[3];
    int k;
    t_reset = 1'b1; t_in_valid = 1'b0; t_switch = 1'b0; t_in = '0;

    // Reset state
    drive(1, 1, 1, 99);
    check("reset_out", int'(t_out), 0);
    check("reset_vld", int'(t_out_valid), 0);

    // Basic D=2
    vals24 = '{10, 20, 30, 50, 0, 0};
    outs24 = '{15, 55, 55};
    k = 0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 0, vals24[i]);
      if (i % 2 == 1) begin
        check("d2_vld", int'(t_out_valid), 1);
        check("d2_out", int'(t_out), outs24[k]);
        k++;
      end else begin
        check("d2_nopulse", int'(t_out_valid), 0);
      end
    end
    drive(0, 0, 0, 0);
    check("d2_hold", int'(t_out), 55);

    // D=4 with mode latched at frame start
    drive(1, 0, 0, 0);
    drive(0, 1, 1, 4);
    drive(0, 1, 0, 8);
    check("d4_no_pulse_2nd", int'(t_out_valid), 0);
    drive(0, 1, 0, 12);
    drive(0, 1, 0, 16);
    check("d4_vld", int'(t_out_valid), 1);
    check("d4_out", int'(t_out), 10);

    // Stall: state held while in_valid is low, average truncates
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 7);
    drive(0, 0, 0, 123);
    check("stall_vld0", int'(t_out_valid), 0);
    drive(0, 0, 1, 200);
    check("stall_vld1", int'(t_out_valid), 0);
    drive(0, 1, 1, 8);
    check("stall_vld", int'(t_out_valid), 1);
    check("stall_out", int'(t_out), 7);

    // Wrap modulo 256
    drive(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 0, 255);
      if (i == 1) check("wrap0", int'(t_out), 255);
      if (i == 3) check("wrap1", int'(t_out), 254);
      if (i == 5) check("wrap2", int'(t_out), 253);
    end

    // Reset mid-frame discards partial sum (reset wins over a valid sample)
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 100);
    drive(1, 1, 0, 77);
    drive(0, 1, 0, 20);
    drive(0, 1, 0, 40);
    check("midrst_vld", int'(t_out_valid), 1);
    check("midrst_out", int'(t_out), 30);
    drive(0, 0, 0, 0);
    check("midrst_pulse_once", int'(t_out_valid), 0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(99) < 2) ? 1'b1 : 1'b0,
            ($urandom_range(99) < 70) ? 1'b1 : 1'b0,
            1'($urandom_range(1)),
            int'($urandom_range(255)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decimator.md
DECIMATOR -- requirements
Module: decimator

Interface
REQ-001 The module SHALL have parameter W, default 8, giving the sample and output data width in bits.
REQ-002 The module SHALL have port Clock, input, 1 bit: the single clock; all state changes occur on posedge Clock.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on posedge Clock.
REQ-004 The module SHALL have port in, input, W bits: unsigned input sample.
REQ-005 The module SHALL have port in_valid, input, 1 bit: when 1, `in` is a sample to consume this cycle.
REQ-006 The module SHALL have port switch, input, 1 bit: decimation select, 0 gives D=2 and 1 gives D=4.
REQ-007 The module SHALL have port out, output, W bits: registered filter output, held between updates.
REQ-008 The module SHALL have port out_valid, output, 1 bit: one-cycle pulse marking a new `out` value.

Function
REQ-009 The block SHALL be a switchable decimating 3rd-order FIR filter: it consumes one sample per in_valid cycle and emits one output per D consumed samples.
REQ-010 A sample SHALL be consumed only on a posedge where reset=0 and in_valid=1; when in_valid=0, the counter, accumulator and taps SHALL be unchanged.
REQ-011 The frame state machine SHALL have states S0..S3 (sample index within frame); S0 is the frame start.
REQ-012 On consumption in S0, `switch` SHALL be latched as the frame mode; the latched mode SHALL hold until the frame completes, and switch changes mid-frame SHALL be ignored.
REQ-013 For D=2, the sequence SHALL be S0->S1->S0; for D=4, the sequence SHALL be S0->S1->S2->S3->S0; each transition occurs only on consumption.
REQ-014 The accumulator SHALL be W+2 bits, unsigned, cleared at frame end; each consumed sample SHALL be added to it.
REQ-015 On consumption of the last sample of a frame (S1 for D=2, S3 for D=4), the frame average SHALL be avg = (acc + in) >> log2(D), truncating with no rounding and taking the low W bits.
REQ-016 In that same cycle, out SHALL be loaded with (avg + a1 + a2) mod 2^W; a2 SHALL load a1 and a1 SHALL load avg; a1 and a2 are the previous two frame averages.
REQ-017 out_valid SHALL be 1 for exactly the cycle following that posedge and 0 otherwise.
REQ-018 Latency SHALL be zero cycles: out and out_valid are visible immediately after the posedge that consumes the last sample of the frame.
REQ-019 Consecutive frames SHALL run back-to-back with no idle cycle; the sample after the last sample of a frame begins the next frame in S0.
REQ-020 Arithmetic SHALL wrap modulo 2^W with no saturation; the accumulator SHALL never overflow, since 4*(2^W-1) < 2^(W+2).

Reset
REQ-021 When reset=1 at a posedge, the block SHALL set out=0, out_valid=0, acc=0, a1=0, a2=0, state=S0 and latched mode=D2, regardless of in_valid.
REQ-022 Reset asserted mid-frame SHALL discard the partial frame; the first consumed sample after reset deasserts SHALL start a new frame.
REQ-023 Reset SHALL take priority over consumption in the same cycle.

Verification
REQ-024 Basic D=2: after reset, switch=0, in_valid=1, in=10,20,30,50,0,0 -> out_valid pulses after the 2nd, 4th and 6th samples with out=15, 55, 55; out is held between pulses.
REQ-025 D=4 with mode latch: switch=1 at the first sample, then switch=0, in=4,8,12,16 -> a single out_valid pulse after the 4th sample with out=10; no pulse after the 2nd sample.
REQ-026 Stall and truncation: switch=0, in=7 (valid), two cycles of in_valid=0, in=8 (valid) -> out=7 with the pulse arriving exactly 2 cycles later than in an unstalled run; state is unchanged during the stall.
REQ-027 Wrap: switch=0, in=255 continuously for 6 samples -> out=255, 254, 253 on successive pulses.
REQ-028 Reset mid-frame: switch=0, in=100 consumed, then reset for 1 cycle, then in=20,40 -> out=30 with out_valid for one cycle; 100 does not contribute.
